// File: rtl/filter_peak_detector.sv
// Pulse peak detector: tracks samples above a live threshold, reports the maximum and its
// timestamp when the pulse ends, with a single-entry valid/ready output slot.
module filter_peak_detector #(
   parameter int unsigned SIZE_FILTER_DATA = 16,
   parameter int unsigned MIN_WIDTH        = 3,
   parameter int unsigned TS_W             = 32
) (
   input  logic                               clk,
   input  logic                               reset,
   input  logic signed [SIZE_FILTER_DATA+4:0] input_data,
   input  logic signed [SIZE_FILTER_DATA+4:0] threshold,
   input  logic                               peak_ready,
   output logic                               peak_valid,
   output logic signed [SIZE_FILTER_DATA+4:0] peak_amplitude,
   output logic        [TS_W-1:0]             peak_time,
   output logic        [15:0]                 lost_count
);

   localparam int unsigned W = SIZE_FILTER_DATA + 5;
   localparam logic [7:0] MinWidth = 8'(MIN_WIDTH);

   typedef enum logic [0:0] {Armed, Track} state_t;

   state_t               state;
   logic [TS_W-1:0]      ts;
   logic [7:0]           width;
   logic signed [W-1:0]  max_amp;
   logic [TS_W-1:0]      max_ts;

   logic above;
   logic slot_free;

   assign above     = input_data > threshold;
   assign slot_free = !peak_valid || peak_ready;

   always_ff @(posedge clk or posedge reset) begin
      if (reset) begin
         state          <= Armed;
         ts             <= '0;
         width          <= '0;
         max_amp        <= '0;
         max_ts         <= '0;
         peak_valid     <= 1'b0;
         peak_amplitude <= '0;
         peak_time      <= '0;
         lost_count     <= '0;
      end else begin
         ts <= ts + 1'b1;
         // A completed transfer frees the slot; a pulse ending on this edge may refill it below.
         if (peak_valid && peak_ready) begin
            peak_valid <= 1'b0;
         end
         unique case (state)
            Armed: begin
               if (above) begin
                  state   <= Track;
                  max_amp <= input_data;
                  max_ts  <= ts;
                  width   <= 8'd1;
               end
            end
            Track: begin
               if (above) begin
                  if (width != 8'd255) begin
                     width <= width + 8'd1;
                  end
                  // Strict compare keeps the earliest timestamp on ties.
                  if (input_data > max_amp) begin
                     max_amp <= input_data;
                     max_ts  <= ts;
                  end
               end else begin
                  state <= Armed;
                  if (width >= MinWidth) begin
                     if (slot_free) begin
                        peak_valid     <= 1'b1;
                        peak_amplitude <= max_amp;
                        peak_time      <= max_ts;
                     end else if (lost_count != 16'hFFFF) begin
                        lost_count <= lost_count + 16'd1;
                     end
                  end
               end
            end
            default: state <= Armed;
         endcase
      end
   end

endmodule

// File: doc/filter_peak_detector.md
FILTER_PEAK_DETECTOR -- requirements
Module: filter_peak_detector

Interface
REQ-001 Parameters SHALL be: SIZE_FILTER_DATA, default 16, base width of filter output (sample width = SIZE_FILTER_DATA+5); MIN_WIDTH, default 3, minimum accepted pulse length in samples, legal range 1..255; TS_W, default 32, timestamp width.
REQ-002 Ports SHALL be:
- clk  in  1  sole clock, rising edge.
- reset  in  1  asynchronous, active-high.
- input_data  in  SIZE_FILTER_DATA+5  signed shaped sample, one per clock, straight from the shaping filter output_data.
- threshold  in  SIZE_FILTER_DATA+5  signed trigger level, compared live every cycle.
- peak_ready  in  1  downstream accepts peak.
- peak_valid  out  1  peak record available.
- peak_amplitude  out  SIZE_FILTER_DATA+5  signed maximum sample of pulse.
- peak_time  out  TS_W  timestamp of that maximum.
- lost_count  out  16  peaks dropped because output slot was full.

Function
REQ-003 A free-running timestamp counter ts SHALL increment on every clk edge out of reset and wrap from 2^TS_W-1 to 0; the sample captured at an edge is tagged with ts value before that increment.
REQ-004 Comparisons SHALL be signed; "above" means input_data > threshold (strict).
REQ-005 FSM states SHALL be ARMED and TRACK; reset state ARMED.
REQ-006 ARMED: sample above -> TRACK, max<=sample, max_ts<=ts, width<=1; else stay.
REQ-007 TRACK, sample above: width<=width+1 saturating at 255; if sample > max then max<=sample, max_ts<=ts (ties keep earliest timestamp).
REQ-008 TRACK, sample not above: pulse ends, state<=ARMED on that same edge; the terminating sample SHALL NOT be eligible to re-arm in that cycle.
REQ-009 At pulse end with width < MIN_WIDTH the pulse SHALL be discarded silently.
REQ-010 At pulse end with width >= MIN_WIDTH: if slot free (peak_valid=0, or peak_valid=1 and peak_ready=1 this cycle), load peak_amplitude<=max, peak_time<=max_ts, peak_valid<=1 on that same edge; else drop and increment lost_count.
REQ-011 Latency: peak_valid SHALL rise on the edge that captures the first not-above sample; no further pipeline.
REQ-012 Handshake: transfer occurs on an edge where peak_valid=1 and peak_ready=1; peak_valid then clears unless REQ-010 loads a new peak on that edge, in which case it stays 1 with new data and no loss is counted.
REQ-013 While peak_valid=1 and peak_ready=0, peak_amplitude and peak_time SHALL hold stable.
REQ-014 lost_count SHALL saturate at 65535 and clear only on reset.
REQ-015 peak_valid SHALL NOT depend combinationally on peak_ready.

Reset
REQ-016 On reset assertion, asynchronously: state ARMED, ts=0, width=0, max=0, max_ts=0, peak_valid=0, peak_amplitude=0, peak_time=0, lost_count=0.
REQ-017 Reset mid-TRACK or with a pending peak SHALL discard both; after release a new threshold crossing is required before any peak.

Verification (threshold=100, MIN_WIDTH=3 unless stated)
REQ-018 Samples 0,150,300,200,50 at ts 10..14, peak_ready=1 -> peak_valid high for exactly one cycle after edge ts=14, amplitude 300, time 12.
REQ-019 Samples 150,160,0 -> width 2, no peak_valid, lost_count stays 0.
REQ-020 Samples 200,250,250,90 starting ts 40 -> amplitude 250, time 41.
REQ-021 peak_ready=0, two valid pulses (max 300 then 500) -> first held stable, lost_count=1; then peak_ready=1 -> 300 transferred, no 500 record.
REQ-022 Pending peak handshaken on the same edge a second pulse ends -> peak_valid stays 1, data switches to second peak, lost_count unchanged.
REQ-023 threshold=-300, samples -200,-100,-150,-400 -> amplitude -100 (signed compare); reset pulsed during a later TRACK -> all outputs 0, no peak until next crossing.
